// File: rtl/multi_channel_watchdog.sv
// multi_channel_watchdog
//   N-channel heartbeat watchdog. Each channel runs its own idle counter and trips
//   (sticky) after TIMEOUT cycles without a heartbeat. Any new trip starts or
//   extends a RST_PULSE-cycle force_reset request.
//
//   Optional feature macro: WD_WINDOW_EN. When defined, a heartbeat arriving while
//   the counter is below WIN_MIN is an early kick and trips the channel. The first
//   heartbeat after entering RUN is exempt.
//
// Ports
//   clk          in   1       rising-edge clock
//   rstn         in   1       asynchronous active-low reset
//   enable       in   NUM_CH  per-channel enable (level)
//   heartbeat    in   NUM_CH  per-channel kick, sampled every cycle
//   clear        in   1       clears trips/status and restarts every channel
//   warning      out  NUM_CH  counter has reached WARN_AT while running
//   triggered    out  NUM_CH  sticky trip flags
//   force_reset  out  1       stretched reset request
//   any_fault    out  1       OR of triggered
//   first_fault  out  FW      index of first channel tripped since reset/clear
//   early_kick   out  NUM_CH  sticky early-heartbeat flags (0 without WD_WINDOW_EN)
module multi_channel_watchdog #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned TIMEOUT   = 1_000_000,
   parameter int unsigned WARN_AT   = 750_000,
   parameter int unsigned WIN_MIN   = 1000,
   parameter int unsigned RST_PULSE = 16,
   localparam int unsigned FW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [NUM_CH-1:0] enable,
   input  logic [NUM_CH-1:0] heartbeat,
   input  logic              clear,
   output logic [NUM_CH-1:0] warning,
   output logic [NUM_CH-1:0] triggered,
   output logic              force_reset,
   output logic              any_fault,
   output logic [FW-1:0]     first_fault,
   output logic [NUM_CH-1:0] early_kick
);

   localparam int unsigned      PW        = $clog2(RST_PULSE + 1);
   localparam logic [CNT_W-1:0] CntLast   = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CntWarn   = CNT_W'(WARN_AT);
   localparam logic [PW-1:0]    PulseLoad = PW'(RST_PULSE);

   if (NUM_CH < 1 || TIMEOUT < 2 || WARN_AT >= TIMEOUT || WIN_MIN >= WARN_AT ||
       RST_PULSE < 1) begin : g_bad_params
      $error("multi_channel_watchdog: illegal parameter combination");
   end

   typedef enum logic [1:0] {StIdle, StRun, StTripped} state_e;

   state_e            state_q [NUM_CH];
   state_e            state_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q   [NUM_CH];
   logic [CNT_W-1:0]  cnt_d   [NUM_CH];
   logic [NUM_CH-1:0] warn_q, warn_d;
   logic [NUM_CH-1:0] trig_q, trig_d;
   logic [NUM_CH-1:0] new_trip;
   logic [PW-1:0]     pulse_q, pulse_d;
   logic [FW-1:0]     first_q, first_d;

`ifdef WD_WINDOW_EN
   localparam logic [CNT_W-1:0] WinMin = CNT_W'(WIN_MIN);
   // kicked: a heartbeat has already been accepted since entering RUN.
   logic [NUM_CH-1:0] kicked_q, kicked_d;
   logic [NUM_CH-1:0] early_q, early_d;
`endif

   // Per-channel state machines
   always_comb begin
      warn_d   = warn_q;
      trig_d   = trig_q;
      new_trip = '0;
`ifdef WD_WINDOW_EN
      kicked_d = kicked_q;
      early_d  = early_q;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            StIdle: begin
               cnt_d[i]  = '0;
               warn_d[i] = 1'b0;
               if (enable[i]) begin
                  state_d[i] = StRun;
`ifdef WD_WINDOW_EN
                  kicked_d[i] = 1'b0;
`endif
               end
            end
            StRun: begin
               if (!enable[i]) begin
                  state_d[i] = StIdle;
                  cnt_d[i]   = '0;
                  warn_d[i]  = 1'b0;
               end
`ifdef WD_WINDOW_EN
               else if (heartbeat[i] && kicked_q[i] && (cnt_q[i] < WinMin)) begin
                  state_d[i]  = StTripped;
                  warn_d[i]   = 1'b0;
                  trig_d[i]   = 1'b1;
                  early_d[i]  = 1'b1;
                  new_trip[i] = 1'b1;
               end
`endif
               else if (heartbeat[i]) begin
                  // Heartbeat wins over a trip in the same cycle.
                  cnt_d[i]  = '0;
                  warn_d[i] = 1'b0;
`ifdef WD_WINDOW_EN
                  kicked_d[i] = 1'b1;
`endif
               end else if (cnt_q[i] == CntLast) begin
                  state_d[i]  = StTripped;
                  warn_d[i]   = 1'b0;
                  trig_d[i]   = 1'b1;
                  new_trip[i] = 1'b1;
               end else begin
                  cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                  warn_d[i] = (cnt_q[i] + CNT_W'(1)) >= CntWarn;
               end
            end
            StTripped: ;  // frozen until clear or reset
            default: state_d[i] = StIdle;
         endcase
         // clear overrides everything, including a trip in the same cycle.
         if (clear) begin
            state_d[i]  = enable[i] ? StRun : StIdle;
            cnt_d[i]    = '0;
            warn_d[i]   = 1'b0;
            trig_d[i]   = 1'b0;
            new_trip[i] = 1'b0;
`ifdef WD_WINDOW_EN
            kicked_d[i] = 1'b0;
            early_d[i]  = 1'b0;
`endif
         end
      end
   end

   // Reset pulse stretcher and first-fault capture
   always_comb begin
      pulse_d = pulse_q;
      first_d = first_q;
      if (|new_trip) begin
         pulse_d = PulseLoad;
      end else if (pulse_q != '0) begin
         pulse_d = pulse_q - PW'(1);
      end
      if (clear) begin
         first_d = '0;
      end else if (!(|trig_q) && (|new_trip)) begin
         // Descending scan so the lowest simultaneous index wins.
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (new_trip[i]) first_d = FW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= StIdle;
            cnt_q[i]   <= '0;
         end
         warn_q  <= '0;
         trig_q  <= '0;
         pulse_q <= '0;
         first_q <= '0;
`ifdef WD_WINDOW_EN
         kicked_q <= '0;
         early_q  <= '0;
`endif
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         warn_q  <= warn_d;
         trig_q  <= trig_d;
         pulse_q <= pulse_d;
         first_q <= first_d;
`ifdef WD_WINDOW_EN
         kicked_q <= kicked_d;
         early_q  <= early_d;
`endif
      end
   end

   assign warning     = warn_q;
   assign triggered   = trig_q;
   assign force_reset = (pulse_q != '0);
   assign any_fault   = |trig_q;
   assign first_fault = first_q;
`ifdef WD_WINDOW_EN
   assign early_kick  = early_q;
`else
   assign early_kick  = '0;
`endif

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Self-checking bench for multi_channel_watchdog (NUM_CH=2, CNT_W=8, TIMEOUT=20,
// WARN_AT=15, WIN_MIN=5, RST_PULSE=4). A behavioural model tracks every cycle;
// a vector table and hand sequences add fixed expectations.
module tb_multi_channel_watchdog;

   localparam int unsigned NUM_CH    = 2;
   localparam int unsigned CNT_W     = 8;
   localparam int unsigned TIMEOUT   = 20;
   localparam int unsigned WARN_AT   = 15;
   localparam int unsigned WIN_MIN   = 5;
   localparam int unsigned RST_PULSE = 4;
`ifdef WD_WINDOW_EN
   localparam bit WINDOW = 1'b1;
`else
   localparam bit WINDOW = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [1:0] enable = 2'b00;
   logic [1:0] heartbeat = 2'b00;
   logic       clear = 1'b0;
   logic [1:0] warning, triggered, early_kick;
   logic       force_reset, any_fault, first_fault;

   int n_tests = 0;
   int n_fail  = 0;

   multi_channel_watchdog #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .WARN_AT(WARN_AT),
      .WIN_MIN(WIN_MIN), .RST_PULSE(RST_PULSE)
   ) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .heartbeat(heartbeat), .clear(clear),
      .warning(warning), .triggered(triggered), .force_reset(force_reset),
      .any_fault(any_fault), .first_fault(first_fault), .early_kick(early_kick)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

   // ---------------- reference model ----------------
   logic [1:0] m_run, m_trip, m_early, m_kicked;
   int         m_age [2];
   int         m_pulse;
   int         m_first;

   task automatic model_reset();
      m_run = '0; m_trip = '0; m_early = '0; m_kicked = '0;
      m_age[0] = 0; m_age[1] = 0;
      m_pulse = 0; m_first = 0;
   endtask

   task automatic model_step(input logic [1:0] en, input logic [1:0] hb, input logic clr);
      logic [1:0] newt;
      bit had_fault;
      newt = '0;
      had_fault = (m_trip != 0);
      for (int c = 0; c < 2; c++) begin
         if (clr) begin
            m_run[c] = en[c]; m_age[c] = 0; m_trip[c] = 0; m_early[c] = 0; m_kicked[c] = 0;
         end else if (m_trip[c]) begin
            // sticky: ignore everything
         end else if (!m_run[c]) begin
            if (en[c]) begin m_run[c] = 1; m_age[c] = 0; m_kicked[c] = 0; end
         end else if (!en[c]) begin
            m_run[c] = 0; m_age[c] = 0;
         end else if (hb[c]) begin
            if (WINDOW && m_kicked[c] && m_age[c] < int'(WIN_MIN)) begin
               m_trip[c] = 1; m_early[c] = 1; newt[c] = 1;
            end else begin
               m_age[c] = 0; m_kicked[c] = 1;
            end
         end else if (m_age[c] == int'(TIMEOUT) - 1) begin
            m_trip[c] = 1; newt[c] = 1;
         end else begin
            m_age[c]++;
         end
      end
      if (clr) m_first = 0;
      else if (newt != 0 && !had_fault) m_first = newt[0] ? 0 : 1;
      if (newt != 0) m_pulse = RST_PULSE;
      else if (m_pulse > 0) m_pulse--;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [1:0] ew;
      for (int c = 0; c < 2; c++)
         ew[c] = m_run[c] && !m_trip[c] && (m_age[c] >= int'(WARN_AT));
      check("mdl_warning", 32'(warning), 32'(ew));
      check("mdl_triggered", 32'(triggered), 32'(m_trip));
      check("mdl_force_reset", 32'(force_reset), 32'(m_pulse > 0));
      check("mdl_any_fault", 32'(any_fault), 32'(m_trip != 0));
      check("mdl_first_fault", 32'(first_fault), 32'(m_first));
      check("mdl_early_kick", 32'(early_kick), 32'(m_early));
   endtask

   // One clock: drive, edge, advance model, sample 1 time unit later.
   task automatic cycle(input logic [1:0] en, input logic [1:0] hb, input logic clr);
      enable = en; heartbeat = hb; clear = clr;
      @(posedge clk);
      model_step(en, hb, clr);
      #1;
      check_model();
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop before the next edge.
   task automatic do_reset();
      rstn = 1'b0; enable = '0; heartbeat = '0; clear = 1'b0;
      #2;
      model_reset();
      check("rst_warning", 32'(warning), 32'd0);
      check("rst_triggered", 32'(triggered), 32'd0);
      check("rst_force_reset", 32'(force_reset), 32'd0);
      check("rst_any_fault", 32'(any_fault), 32'd0);
      check("rst_first_fault", 32'(first_fault), 32'd0);
      check("rst_early_kick", 32'(early_kick), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0] en;
      logic [1:0] hb;
      logic       clr;
      int         n;
      logic [1:0] warn;
      logic [1:0] trig;
      logic       frc;
      logic       any;
      logic       first;
   } vec_t;

   localparam int NV = 22;
   vec_t vecs [NV];

   initial begin
      int hi;
      int k_used;
      bit found;
      logic [1:0] cur_en;
      logic [1:0] hb;

      //           en     hb    clr  n    warn   trig  frc   any   first
      vecs[0]  = '{2'b01, 2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{2'b01, 2'b00, 1'b0, 14, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{2'b01, 2'b00, 1'b0, 1,  2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{2'b01, 2'b00, 1'b0, 4,  2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{2'b01, 2'b00, 1'b0, 1,  2'b00, 2'b01, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{2'b01, 2'b00, 1'b0, 3,  2'b00, 2'b01, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{2'b01, 2'b00, 1'b0, 1,  2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{2'b00, 2'b00, 1'b1, 1,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{2'b01, 2'b00, 1'b0, 1,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{2'b01, 2'b00, 1'b0, 19, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{2'b01, 2'b01, 1'b0, 1,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{2'b01, 2'b00, 1'b0, 19, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{2'b01, 2'b00, 1'b0, 1,  2'b00, 2'b01, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{2'b11, 2'b00, 1'b1, 1,  2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{2'b11, 2'b00, 1'b0, 19, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[15] = '{2'b11, 2'b00, 1'b0, 1,  2'b00, 2'b11, 1'b1, 1'b1, 1'b0};
      vecs[16] = '{2'b11, 2'b00, 1'b0, 4,  2'b00, 2'b11, 1'b0, 1'b1, 1'b0};
      vecs[17] = '{2'b10, 2'b00, 1'b1, 1,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{2'b10, 2'b00, 1'b0, 19, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
      vecs[19] = '{2'b10, 2'b00, 1'b0, 1,  2'b00, 2'b10, 1'b1, 1'b1, 1'b1};
      vecs[20] = '{2'b00, 2'b00, 1'b1, 1,  2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
      vecs[21] = '{2'b00, 2'b00, 1'b0, 3,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

      // Power-on reset
      model_reset();
      @(posedge clk);
      #1;
      check("por_triggered", 32'(triggered), 32'd0);
      check("por_force_reset", 32'(force_reset), 32'd0);
      check("por_warning", 32'(warning), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         for (int k = 0; k < vecs[i].n; k++) cycle(vecs[i].en, vecs[i].hb, vecs[i].clr);
         check($sformatf("vec%0d_warning", i), 32'(warning), 32'(vecs[i].warn));
         check($sformatf("vec%0d_triggered", i), 32'(triggered), 32'(vecs[i].trig));
         check($sformatf("vec%0d_force_reset", i), 32'(force_reset), 32'(vecs[i].frc));
         check($sformatf("vec%0d_any_fault", i), 32'(any_fault), 32'(vecs[i].any));
         check($sformatf("vec%0d_first_fault", i), 32'(first_fault), 32'(vecs[i].first));
      end

      // Staggered trips: ch1 two cycles behind ch0, pulse extended to 6 cycles.
      cycle(2'b01, 2'b00, 1'b0);
      cycle(2'b01, 2'b00, 1'b0);
      cycle(2'b11, 2'b00, 1'b0);
      found = 1'b0;
      k_used = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         cycle(2'b11, 2'b00, 1'b0);
         k_used++;
         if (triggered[0]) found = 1'b1;
      end
      check("stag_trip0_seen", 32'(found), 32'd1);
      check("stag_trip0_latency", 32'(k_used), 32'd18);
      check("stag_trig_first", 32'(triggered), 32'b01);
      hi = int'(force_reset);
      for (int k = 0; k < 9; k++) begin
         cycle(2'b11, 2'b00, 1'b0);
         hi += int'(force_reset);
      end
      check("stag_pulse_len", 32'(hi), 32'd6);
      check("stag_trig_both", 32'(triggered), 32'b11);
      check("stag_first_fault", 32'(first_fault), 32'd0);

      // Reset asserted during a force_reset pulse
      cycle(2'b11, 2'b00, 1'b1);
      repeat (20) cycle(2'b11, 2'b00, 1'b0);
      cycle(2'b11, 2'b00, 1'b0);
      check("midpulse_force_before", 32'(force_reset), 32'd1);
      do_reset();

      // Window check: exempt first kick, then an early kick.
      cycle(2'b01, 2'b00, 1'b0);
      repeat (10) cycle(2'b01, 2'b00, 1'b0);
      cycle(2'b01, 2'b01, 1'b0);
      check("win_first_kick_trig", 32'(triggered), 32'd0);
      repeat (3) cycle(2'b01, 2'b00, 1'b0);
      cycle(2'b01, 2'b01, 1'b0);
      check("win_early_kick", 32'(early_kick), WINDOW ? 32'd1 : 32'd0);
      check("win_trig", 32'(triggered), WINDOW ? 32'd1 : 32'd0);
      hi = int'(force_reset);
      for (int k = 0; k < 7; k++) begin
         cycle(2'b01, 2'b00, 1'b0);
         hi += int'(force_reset);
      end
      check("win_pulse_len", 32'(hi), WINDOW ? 32'd4 : 32'd0);
      cycle(2'b00, 2'b00, 1'b1);
      repeat (5) cycle(2'b00, 2'b00, 1'b0);

      // clear coincident with a trip: clear wins, no pulse.
      cycle(2'b01, 2'b00, 1'b0);
      repeat (19) cycle(2'b01, 2'b00, 1'b0);
      check("clrtrip_warn_before", 32'(warning), 32'b01);
      cycle(2'b01, 2'b00, 1'b1);
      check("clrtrip_trig", 32'(triggered), 32'd0);
      check("clrtrip_force", 32'(force_reset), 32'd0);
      cycle(2'b01, 2'b00, 1'b0);
      check("clrtrip_force_after", 32'(force_reset), 32'd0);
      check("clrtrip_any", 32'(any_fault), 32'd0);

      // Randomised run against the model
      cur_en = 2'b11;
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         for (int c = 0; c < 2; c++) begin
            if ($urandom_range(0, 59) == 0) cur_en[c] = ~cur_en[c];
            hb[c] = ($urandom_range(0, 11) == 0);
         end
         cycle(cur_en, hb, $urandom_range(0, 59) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
